// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter that places the CPU
// load/store unit (M0) and the debug/program-load DMA (M1) on the single
// memory_system data port.
//   arb_state_t : arbiter FSM state, which records the last owner
//   rsp_tag_t   : one-deep response tag captured at grant time
//   BE_WIDTH    : byte-enable width for the default data width
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWN_M0 = 2'd1,
    ARB_OWN_M1 = 2'd2
  } arb_state_t;

  // owner: 0 = M0, 1 = M1. is_write selects a zero response payload.
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_write;
  } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports and the memory-side port of the arbiter.
//   mN_req/addr/we/wdata/be : request from requester N, held until mN_gnt
//   mN_gnt                  : request accepted this cycle
//   mN_rvalid/mN_rdata      : response one cycle after the grant
//   mem_addr/wdata/read/write/be : command to memory_system dmem_*
//   mem_rdata/mem_ready     : read data (registered in memory) and ready
// Modports:
//   slave  : the arbiter's view (accepts requests, drives memory)
//   master : the environment's view (requesters plus memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) ();

  localparam int BW = DW / 8;

  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_we;
  logic [DW-1:0] m0_wdata;
  logic [BW-1:0] m0_be;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_we;
  logic [DW-1:0] m1_wdata;
  logic [BW-1:0] m1_be;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_we, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write, mem_be,
    input  mem_rdata, mem_ready
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_we, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_be,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dmem_arb_fsm.sv
// -----------------------------------------------------------------------------
// dmem_arb_fsm
// Owner-tracking arbitration FSM with a burst cap. Remembers the last owner
// and how many consecutive grants it has received; once that count reaches
// MAX_BURST while the other requester waits, ownership is handed over.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req0_i, req1_i   : requests from M0 / M1
//   ready_i          : memory ready; low freezes the FSM and blocks grants
//   gnt0_o, gnt1_o   : combinational grants, at most one per cycle
// -----------------------------------------------------------------------------
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int M0_PRIO   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic ready_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               PRIO_M0 = (M0_PRIO != 0);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant0, grant1;
  logic             arbEnable;

  // Grants are also held off while reset is asserted, so a requester that is
  // already driving req is never acknowledged without a response to follow.
  assign arbEnable = ready_i & rst_n;

  // State and burst-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant selection and next state. The owner keeps the port while the other
  // side is idle or its burst budget is not spent; otherwise a waiting
  // requester takes over. The count saturates at MAX_BURST so an
  // uncontested owner keeps being granted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant0  = 1'b0;
    grant1  = 1'b0;

    if (arbEnable) begin
      case (state_q)
        ARB_IDLE: begin
          if (req0_i && (!req1_i || PRIO_M0)) begin
            grant0 = 1'b1;
          end else if (req1_i) begin
            grant1 = 1'b1;
          end
        end
        ARB_OWN_M0: begin
          if (req0_i && (!req1_i || (cnt_q < CNT_MAX))) begin
            grant0 = 1'b1;
          end else if (req1_i) begin
            grant1 = 1'b1;
          end
        end
        ARB_OWN_M1: begin
          if (req1_i && (!req0_i || (cnt_q < CNT_MAX))) begin
            grant1 = 1'b1;
          end else if (req0_i) begin
            grant0 = 1'b1;
          end
        end
        default: begin
        end
      endcase

      if (grant0) begin
        state_d = ARB_OWN_M0;
        if (state_q == ARB_OWN_M0) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_ONE;
        end
      end else if (grant1) begin
        state_d = ARB_OWN_M1;
        if (state_q == ARB_OWN_M1) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_ONE;
        end
      end else begin
        // No request (or an illegal encoding): release ownership.
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign gnt0_o = grant0;
  assign gnt1_o = grant1;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the memory_system data port between the CPU load/store unit (M0) and
// the debug/program-load DMA (M1). Grants are combinational; the granted
// master's payload is forwarded unchanged to memory, and a one-deep response
// tag routes the 1-cycle-latency read data back to the issuer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   bus (slave modport)    : both requester ports plus the memory port
//   gnt_count0, gnt_count1 : free-running grant counters (debug, wrap)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int M0_PRIO    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic [31:0]   gnt_count0,
  output logic [31:0]   gnt_count1
);

  import dmem_arb_pkg::*;

  localparam int BEW = DATA_WIDTH / 8;

  logic                  gnt0, gnt1;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [BEW-1:0]        memBe;
  logic                  memRead, memWrite;
  rsp_tag_t              rspTag_q, rspTag_d;
  logic [31:0]           gntCount0_q, gntCount1_q;
  logic                  rsp0, rsp1;

  dmem_arb_fsm #(
    .MAX_BURST (MAX_BURST),
    .M0_PRIO   (M0_PRIO)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0_i  (bus.m0_req),
    .req1_i  (bus.m1_req),
    .ready_i (bus.mem_ready),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1)
  );

  // Payload mux: the memory port sees the granted master's command, and an
  // all-zero idle command otherwise so nothing stale reaches memory.
  always_comb begin
    memAddr  = '0;
    memWdata = '0;
    memBe    = '0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    if (gnt0) begin
      memAddr  = bus.m0_addr;
      memWdata = bus.m0_wdata;
      memBe    = bus.m0_be;
      memRead  = ~bus.m0_we;
      memWrite = bus.m0_we;
    end else if (gnt1) begin
      memAddr  = bus.m1_addr;
      memWdata = bus.m1_wdata;
      memBe    = bus.m1_be;
      memRead  = ~bus.m1_we;
      memWrite = bus.m1_we;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.mem_be    = memBe;
  assign bus.mem_read  = memRead;
  assign bus.mem_write = memWrite;

  // Response tag for the access issued this cycle. Memory answers exactly one
  // cycle later, so a single entry sustains one response per cycle.
  always_comb begin
    rspTag_d = '0;
    if (gnt0 | gnt1) begin
      rspTag_d.valid    = 1'b1;
      rspTag_d.owner    = gnt1;
      rspTag_d.is_write = memWrite;
    end
  end

  // Response tag and grant counters; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspTag_q    <= '0;
      gntCount0_q <= '0;
      gntCount1_q <= '0;
    end else begin
      rspTag_q <= rspTag_d;
      if (gnt0) begin
        gntCount0_q <= gntCount0_q + 32'd1;
      end
      if (gnt1) begin
        gntCount1_q <= gntCount1_q + 32'd1;
      end
    end
  end

  // Route the response to its issuer; writes return a zero payload.
  assign rsp0 = rspTag_q.valid & ~rspTag_q.owner;
  assign rsp1 = rspTag_q.valid & rspTag_q.owner;

  assign bus.m0_rvalid = rsp0;
  assign bus.m1_rvalid = rsp1;
  assign bus.m0_rdata  = (rsp0 && !rspTag_q.is_write) ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = (rsp1 && !rspTag_q.is_write) ? bus.mem_rdata : '0;

  assign gnt_count0 = gntCount0_q;
  assign gnt_count1 = gntCount1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives both requesters and a small registered-read memory. A contention
// model (last owner + run length + shadow memory) predicts every output each
// cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;
  localparam int M0_PRIO   = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gnt_count0, gnt_count1;
  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [31:0] memArr [0:63];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_BURST  (MAX_BURST),
    .M0_PRIO    (M0_PRIO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .gnt_count0 (gnt_count0),
    .gnt_count1 (gnt_count1)
  );

  always #5 clk = ~clk;

  // Initial memory image: word w holds 0x89ABCDEF + w*0x11111111.
  function automatic logic [31:0] initWord(input int w);
    return 32'h89AB_CDEF + 32'(w) * 32'h1111_1111;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                             input logic [31:0] newW,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = newW[8*b +: 8];
    end
    return r;
  endfunction

  // Who wins this cycle, from the contention point of view: -1 = nobody.
  function automatic int pickWinner(input bit r0, input bit r1, input bit rdy,
                                    input int owner, input int run);
    if (!rdy || (!r0 && !r1)) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (owner < 0) return (M0_PRIO != 0) ? 0 : 1;
    if (run < MAX_BURST) return owner;
    return 1 - owner;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input bit req, input logic [31:0] addr,
                               input bit we, input logic [31:0] wdata,
                               input logic [3:0] be);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_addr = addr; bus.m0_we = we;
      bus.m0_wdata = wdata; bus.m0_be = be;
    end else begin
      bus.m1_req = req; bus.m1_addr = addr; bus.m1_we = we;
      bus.m1_wdata = wdata; bus.m1_be = be;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Memory: registered read data, byte-enabled writes.
  initial begin
    for (int i = 0; i < 64; i++) memArr[i] = initWord(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_read)  bus.mem_rdata <= memArr[bus.mem_addr[7:2]];
      if (bus.mem_write) memArr[bus.mem_addr[7:2]] =
          mergeBytes(memArr[bus.mem_addr[7:2]], bus.mem_wdata, bus.mem_be);
    end
  end

  // Model and per-cycle compare.
  initial begin : compareProc
    int          owner;
    int          run;
    int          w;
    bit          pendValid;
    int          pendOwner;
    bit          pendWrite;
    logic [31:0] pendData;
    logic [31:0] expCnt0, expCnt1;
    logic [31:0] shadow [0:63];
    logic [31:0] wAddr, wData;
    logic [3:0]  wBe;
    bit          wWe;
    owner = -1; run = 0; pendValid = 0; pendOwner = 0; pendWrite = 0;
    pendData = '0; expCnt0 = '0; expCnt1 = '0;
    for (int i = 0; i < 64; i++) shadow[i] = initWord(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst m0_gnt", bus.m0_gnt, 0);
        checkOutput("rst m1_gnt", bus.m1_gnt, 0);
        checkOutput("rst m0_rvalid", bus.m0_rvalid, 0);
        checkOutput("rst m1_rvalid", bus.m1_rvalid, 0);
        checkOutput("rst m0_rdata", bus.m0_rdata, 0);
        checkOutput("rst m1_rdata", bus.m1_rdata, 0);
        checkOutput("rst mem_read", bus.mem_read, 0);
        checkOutput("rst mem_write", bus.mem_write, 0);
        checkOutput("rst gnt_count0", gnt_count0, 0);
        checkOutput("rst gnt_count1", gnt_count1, 0);
        owner = -1; run = 0; pendValid = 0; expCnt0 = '0; expCnt1 = '0;
      end else begin
        checkOutput("m0_rvalid", bus.m0_rvalid, pendValid && pendOwner == 0);
        checkOutput("m1_rvalid", bus.m1_rvalid, pendValid && pendOwner == 1);
        checkOutput("m0_rdata", bus.m0_rdata,
                    (pendValid && pendOwner == 0 && !pendWrite) ? pendData : 32'h0);
        checkOutput("m1_rdata", bus.m1_rdata,
                    (pendValid && pendOwner == 1 && !pendWrite) ? pendData : 32'h0);
        checkOutput("gnt_count0", gnt_count0, expCnt0);
        checkOutput("gnt_count1", gnt_count1, expCnt1);

        w = pickWinner(bus.m0_req, bus.m1_req, bus.mem_ready, owner, run);
        wAddr = '0; wData = '0; wBe = '0; wWe = 0;
        if (w == 0) begin
          wAddr = bus.m0_addr; wData = bus.m0_wdata; wBe = bus.m0_be; wWe = bus.m0_we;
        end else if (w == 1) begin
          wAddr = bus.m1_addr; wData = bus.m1_wdata; wBe = bus.m1_be; wWe = bus.m1_we;
        end
        checkOutput("m0_gnt", bus.m0_gnt, w == 0);
        checkOutput("m1_gnt", bus.m1_gnt, w == 1);
        checkOutput("mem_read", bus.mem_read, (w >= 0) && !wWe);
        checkOutput("mem_write", bus.mem_write, (w >= 0) && wWe);
        checkOutput("mem_addr", bus.mem_addr, wAddr);
        checkOutput("mem_wdata", bus.mem_wdata, wData);
        checkOutput("mem_be", 32'(bus.mem_be), 32'(wBe));

        pendValid = (w >= 0);
        pendOwner = w;
        pendWrite = wWe;
        pendData  = '0;
        if (w >= 0) begin
          pendData = shadow[wAddr[7:2]];
          if (wWe) shadow[wAddr[7:2]] = mergeBytes(shadow[wAddr[7:2]], wData, wBe);
          if (w == 0) expCnt0 = expCnt0 + 1; else expCnt1 = expCnt1 + 1;
        end
        if (bus.mem_ready) begin
          if (w < 0) begin
            owner = -1; run = 0;
          end else begin
            run   = (w == owner) ? ((run < MAX_BURST) ? run + 1 : run) : 1;
            owner = w;
          end
        end
      end
    end
  end

  // Directed sequences with literal expectations.
  initial begin : stimProc
    int burstExp [9];
    int got;
    burstExp = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone M0 read of address 0.
    tick();
    applyStimulus(0, 1, 32'h0, 0, 0, 4'h0);
    sample();
    checkOutput("t1 m0_gnt", bus.m0_gnt, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("t1 m0_rvalid", bus.m0_rvalid, 1);
    checkOutput("t1 m0_rdata", bus.m0_rdata, 32'h89AB_CDEF);
    checkOutput("t1 m1_rvalid", bus.m1_rvalid, 0);

    // Both requesting from reset: four M0, four M1, then M0.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    applyStimulus(0, 1, 32'h20, 0, 0, 4'h0);
    applyStimulus(1, 1, 32'h24, 0, 0, 4'h0);
    for (int i = 0; i < 9; i++) begin
      sample();
      got = bus.m0_gnt ? 0 : (bus.m1_gnt ? 1 : -1);
      checkOutput("burst owner", 32'(got), 32'(burstExp[i]));
      checkOutput("burst onehot", bus.m0_gnt & bus.m1_gnt, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    // M1 partial write, then M0 reads it back.
    applyStimulus(1, 1, 32'h10, 1, 32'hDEAD_BEEF, 4'b0011);
    sample();
    checkOutput("t3 m1_gnt", bus.m1_gnt, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h10, 0, 0, 4'h0);
    sample();
    checkOutput("t3 m1_rvalid", bus.m1_rvalid, 1);
    checkOutput("t3 m1_rdata", bus.m1_rdata, 32'h0);
    checkOutput("t3 m0_gnt", bus.m0_gnt, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("t3 m0_rvalid", bus.m0_rvalid, 1);
    checkOutput("t3 m0_rdata", bus.m0_rdata, 32'hCDF0_BEEF);

    // mem_ready low freezes the owner and its burst count.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    applyStimulus(0, 1, 32'h0, 0, 0, 4'h0);
    applyStimulus(1, 1, 32'h4, 0, 0, 4'h0);
    sample(); checkOutput("t4 pre gnt0 a", bus.m0_gnt, 1);
    tick();
    sample(); checkOutput("t4 pre gnt0 b", bus.m0_gnt, 1);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("t4 stall gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
      checkOutput("t4 stall rd/wr", {bus.mem_read, bus.mem_write}, 0);
      tick();
    end
    bus.mem_ready = 1'b1;
    sample(); checkOutput("t4 resume gnt0 a", bus.m0_gnt, 1);
    tick();
    sample(); checkOutput("t4 resume gnt0 b", bus.m0_gnt, 1);
    tick();
    sample(); checkOutput("t4 handover gnt1", bus.m1_gnt, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Reset the cycle after a grant: the response is dropped.
    tick();
    applyStimulus(0, 1, 32'h4, 0, 0, 4'h0);
    sample(); checkOutput("t5 m0_gnt", bus.m0_gnt, 1);
    tick();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h8, 0, 0, 4'h0);
    sample();
    checkOutput("t5 m0_rvalid", bus.m0_rvalid, 0);
    checkOutput("t5 m0_rdata", bus.m0_rdata, 0);
    checkOutput("t5 m1_gnt", bus.m1_gnt, 0);
    checkOutput("t5 mem_read", bus.mem_read, 0);
    checkOutput("t5 gnt_count0", gnt_count0, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Alternating single requests M0, M1, M0.
    tick();
    applyStimulus(0, 1, 32'h8, 0, 0, 4'h0);
    sample(); checkOutput("t6 gnt0 a", bus.m0_gnt, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'hC, 0, 0, 4'h0);
    sample();
    checkOutput("t6 gnt1", bus.m1_gnt, 1);
    checkOutput("t6 rvalid a", {bus.m0_rvalid, bus.m1_rvalid}, 2'b10);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0, 0, 0, 4'h0);
    sample();
    checkOutput("t6 gnt0 b", bus.m0_gnt, 1);
    checkOutput("t6 rvalid b", {bus.m0_rvalid, bus.m1_rvalid}, 2'b01);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("t6 rvalid c", {bus.m0_rvalid, bus.m1_rvalid}, 2'b10);
    checkOutput("t6 m0_rdata", bus.m0_rdata, 32'h89AB_CDEF);
    checkOutput("t6 gnt_count0", gnt_count0, 2);
    checkOutput("t6 gnt_count1", gnt_count1, 1);

    tick();
    sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
